// File: rtl/i2s_tx.sv
// I2S Philips-format mono transmitter: 16-bit samples duplicated into both slots of a 64-BCLK frame.
// Buffer depth is 1 by default; define I2S_TX_FIFO_EN for a 4-entry FIFO.
module i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] data_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               i2s_bclk,
    output logic               i2s_ws,
    output logic               i2s_sd,
    output logic               underrun
);

    localparam int DATA_W = 16;
`ifdef I2S_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0]            div_cnt;
    logic                     tick;
    logic                     fall;
    logic [5:0]               bit_cnt;
    logic [5:0]               bit_nxt;
    logic [4:0]               slot_pos;
    logic                     frame_start;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [FW-1:0]            fill;
    logic [FW-1:0]            fill_nxt;
    logic                     push;
    logic                     pop;
    logic signed [DATA_W-1:0] mem [2**PW];
    logic signed [DATA_W-1:0] pop_data;
    logic signed [DATA_W-1:0] frame_smp;
    logic signed [DATA_W-1:0] shreg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign tick        = (div_cnt == DIV_LAST);
    assign fall        = tick && i2s_bclk;
    assign bit_nxt     = bit_cnt + 6'd1;
    assign slot_pos    = bit_nxt[4:0];
    assign frame_start = fall && (bit_cnt == 6'd63);
    assign push        = in_valid && in_ready;
    // Pop sees the pre-edge fill, so a sample arriving on a frame-start edge waits for the next frame
    assign pop         = frame_start && (fill != '0);
    assign pop_data    = mem[rd_ptr];

    always_comb begin
        fill_nxt = fill;
        case ({push, pop})
            2'b10:   fill_nxt = fill + FW'(1);
            2'b01:   fill_nxt = fill - FW'(1);
            default: fill_nxt = fill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            i2s_bclk  <= 1'b0;
            bit_cnt   <= 6'd63;
            i2s_ws    <= 1'b0;
            i2s_sd    <= 1'b0;
            underrun  <= 1'b0;
            in_ready  <= 1'b1;
            fill      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_smp <= '0;
            shreg     <= '0;
        end else begin
            div_cnt  <= tick ? '0 : div_cnt + DW'(1);
            if (tick)
                i2s_bclk <= ~i2s_bclk;
            underrun <= frame_start && (fill == '0);
            fill     <= fill_nxt;
            in_ready <= (fill_nxt != FW'(DEPTH));
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            // Serial outputs change only on the BCLK falling edge; slot bit 0 is the Philips delay bit
            if (fall) begin
                bit_cnt <= bit_nxt;
                i2s_ws  <= bit_nxt[5];
                if (frame_start) begin
                    frame_smp <= pop ? pop_data : '0;
                    shreg     <= pop ? pop_data : '0;
                    i2s_sd    <= 1'b0;
                end else if (slot_pos == 5'd0) begin
                    shreg  <= frame_smp;
                    i2s_sd <= 1'b0;
                end else if (slot_pos <= 5'd16) begin
                    i2s_sd <= shreg[DATA_W-1];
                    shreg  <= shreg << 1;
                end else begin
                    i2s_sd <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: continuous reference model on the negedge plus scenario tasks.
module tb_i2s_tx;

    localparam int CLK_DIV = 4;
    localparam int PER     = 2 * CLK_DIV;
    localparam int FRAME   = 64 * PER;
`ifdef I2S_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, i2s_bclk, i2s_ws, i2s_sd, underrun;

    int checks = 0;
    int failures = 0;
    int mon_prints = 0;
    int t_edge = 0;

    // reference model state
    int          ecount;
    logic [15:0] q[$];
    logic [15:0] acc[$];
    logic [15:0] cur_smp;
    bit          cur_und;
    logic        exp_ws, exp_sd, exp_und, exp_bclk, exp_rdy;
    logic [15:0] obs_left[16];
    logic [15:0] obs_right[16];
    logic [15:0] exp_word[16];
    int          und_cnt[16];
    bit          extra[16];
    int          cur_frame;
    int          mm, ss, pp, ee, ff;
    bit          mfall;

    i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .i2s_bclk(i2s_bclk), .i2s_ws(i2s_ws),
        .i2s_sd(i2s_sd), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({i2s_bclk, i2s_ws, i2s_sd, underrun, in_ready} !== 5'b00001) begin
                failures++;
                if (mon_prints < 20) $display("FAIL mon_reset_outputs got=%b exp=00001",
                    {i2s_bclk, i2s_ws, i2s_sd, underrun, in_ready});
                mon_prints++;
            end
            ecount = 0; q.delete(); acc.delete(); cur_smp = '0; cur_und = 0;
            exp_ws = 1'b0; exp_sd = 1'b0; cur_frame = 0;
            for (int i = 0; i < 16; i++) begin
                obs_left[i] = '0; obs_right[i] = '0; exp_word[i] = '0;
                und_cnt[i] = 0; extra[i] = 0;
            end
        end else begin
            mfall    = (ecount > 0) && (ecount % PER == 0);
            exp_und  = 1'b0;
            exp_bclk = ((ecount / CLK_DIV) % 2) == 1;
            exp_rdy  = (q.size() < DEPTH);
            if (mfall) begin
                mm = ecount / PER; ss = (mm - 1) % 64; pp = ss % 32;
                cur_frame = (mm - 1) / 64;
                exp_ws  = (ss >= 32);
                exp_sd  = (pp >= 1 && pp <= 16) ? cur_smp[16 - pp] : 1'b0;
                exp_und = (ss == 0) && cur_und;
            end
            checks += 5;
            if (i2s_bclk !== exp_bclk) begin
                failures++; if (mon_prints < 20) $display("FAIL mon_bclk edge=%0d got=%0b exp=%0b", ecount, i2s_bclk, exp_bclk); mon_prints++;
            end
            if (i2s_ws !== exp_ws) begin
                failures++; if (mon_prints < 20) $display("FAIL mon_ws edge=%0d got=%0b exp=%0b", ecount, i2s_ws, exp_ws); mon_prints++;
            end
            if (i2s_sd !== exp_sd) begin
                failures++; if (mon_prints < 20) $display("FAIL mon_sd edge=%0d got=%0b exp=%0b", ecount, i2s_sd, exp_sd); mon_prints++;
            end
            if (underrun !== exp_und) begin
                failures++; if (mon_prints < 20) $display("FAIL mon_underrun edge=%0d got=%0b exp=%0b", ecount, underrun, exp_und); mon_prints++;
            end
            if (in_ready !== exp_rdy) begin
                failures++; if (mon_prints < 20) $display("FAIL mon_in_ready edge=%0d got=%0b exp=%0b", ecount, in_ready, exp_rdy); mon_prints++;
            end
            if (mfall && cur_frame < 16) begin
                if (pp >= 1 && pp <= 16) begin
                    if (ss < 32) obs_left[cur_frame][16 - pp] = i2s_sd;
                    else         obs_right[cur_frame][16 - pp] = i2s_sd;
                end else if (i2s_sd !== 1'b0) begin
                    extra[cur_frame] = 1;
                end
            end
            if (underrun === 1'b1 && cur_frame < 16) und_cnt[cur_frame]++;
            // model the upcoming edge: frame-start pop first, then the handshake
            ee = ecount + 1;
            if ((ee % PER == 0) && (((ee / PER) - 1) % 64 == 0)) begin
                ff = (ee / PER - 1) / 64;
                if (q.size() > 0) begin cur_smp = q.pop_front(); cur_und = 0; end
                else begin cur_smp = '0; cur_und = 1; end
                if (ff < 16) exp_word[ff] = cur_smp;
            end
            if (in_valid && in_ready) begin
                q.push_back(data_in);
                acc.push_back(data_in);
            end
            ecount++;
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            t_edge++;
        end
    endtask

    task automatic wait_until(input int n);
        if (n > t_edge) wait_edges(n - t_edge);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        t_edge = 0;
    endtask

    task automatic test_reset();
        logic b[10];
        logic ws8, und8, und9;
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({i2s_bclk, i2s_ws, i2s_sd, underrun, in_ready} !== 5'b00001) begin
            failures++; $display("FAIL reset_values got=%b exp=00001", {i2s_bclk, i2s_ws, i2s_sd, underrun, in_ready});
        end
        rst_n = 1'b1; t_edge = 0;
        ws8 = 1'b1; und8 = 1'b0; und9 = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            wait_edges(1);
            b[e] = i2s_bclk;
            if (e == 8) begin ws8 = i2s_ws; und8 = underrun; end
            if (e == 9) und9 = underrun;
        end
        checks += 6;
        if (b[3] !== 1'b0) begin failures++; $display("FAIL bclk_edge3 got=%0b exp=0", b[3]); end
        if (b[4] !== 1'b1) begin failures++; $display("FAIL bclk_rise4 got=%0b exp=1", b[4]); end
        if (b[7] !== 1'b1) begin failures++; $display("FAIL bclk_edge7 got=%0b exp=1", b[7]); end
        if (b[8] !== 1'b0) begin failures++; $display("FAIL bclk_fall8 got=%0b exp=0", b[8]); end
        if (ws8 !== 1'b0) begin failures++; $display("FAIL ws_at_first_fall got=%0b exp=0", ws8); end
        if ({und8, und9} !== 2'b10) begin failures++; $display("FAIL underrun_first_frame got=%b exp=10", {und8, und9}); end
    endtask

    task automatic test_pattern();
        do_reset();
        data_in = 16'hA5C3; in_valid = 1'b1;
        wait_edges(1);
        in_valid = 1'b0;
        wait_until(2 * FRAME + 4);
        checks += 6;
        if (obs_left[0] !== 16'hA5C3) begin failures++; $display("FAIL pattern_left got=%h exp=a5c3", obs_left[0]); end
        if (obs_right[0] !== 16'hA5C3) begin failures++; $display("FAIL pattern_right got=%h exp=a5c3", obs_right[0]); end
        if (extra[0] !== 1'b0) begin failures++; $display("FAIL pattern_pad_bits got=%0b exp=0", extra[0]); end
        if (und_cnt[0] != 0) begin failures++; $display("FAIL pattern_underrun0 got=%0d exp=0", und_cnt[0]); end
        if (obs_left[1] !== 16'h0000) begin failures++; $display("FAIL pattern_next_left got=%h exp=0000", obs_left[1]); end
        if (und_cnt[1] != 1) begin failures++; $display("FAIL pattern_underrun1 got=%0d exp=1", und_cnt[1]); end
    endtask

    task automatic test_underrun();
        do_reset();
        wait_until(3 * FRAME + 4);
        for (int f = 0; f < 3; f++) begin
            checks += 3;
            if (und_cnt[f] != 1) begin failures++; $display("FAIL underrun_count f=%0d got=%0d exp=1", f, und_cnt[f]); end
            if ({obs_left[f], obs_right[f]} !== 32'h0) begin failures++; $display("FAIL underrun_data f=%0d got=%h exp=0", f, {obs_left[f], obs_right[f]}); end
            if (extra[f] !== 1'b0) begin failures++; $display("FAIL underrun_pad f=%0d got=%0b exp=0", f, extra[f]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int e = 1; e <= 6 * FRAME; e++) begin
            in_valid = ($urandom_range(0, 299) == 0);
            data_in  = 16'($urandom);
            wait_edges(1);
        end
        in_valid = 1'b0;
        wait_until(6 * FRAME + 8);
        for (int f = 0; f < 6; f++) begin
            checks += 3;
            if (obs_left[f] !== exp_word[f]) begin failures++; $display("FAIL random_left f=%0d got=%h exp=%h", f, obs_left[f], exp_word[f]); end
            if (obs_right[f] !== exp_word[f]) begin failures++; $display("FAIL random_right f=%0d got=%h exp=%h", f, obs_right[f], exp_word[f]); end
            if (extra[f] !== 1'b0) begin failures++; $display("FAIL random_pad f=%0d got=%0b exp=0", f, extra[f]); end
        end
    endtask

    task automatic test_back_to_back();
        int  acc_cnt;
        logic hs, r7, r8, r9;
        do_reset();
        acc_cnt = 0; r7 = 1'bx; r8 = 1'bx; r9 = 1'bx;
        in_valid = 1'b1; data_in = 16'($urandom);
        for (int e = 1; e <= 4 * FRAME + 8; e++) begin
            hs = in_ready;
            wait_edges(1);
            if (hs) begin
                data_in = 16'($urandom);
                if (t_edge <= 7) acc_cnt++;
            end
            if (t_edge == 7) r7 = in_ready;
            if (t_edge == 8) r8 = in_ready;
            if (t_edge == 9) r9 = in_ready;
        end
        in_valid = 1'b0;
        checks += 4;
        if (acc_cnt != DEPTH) begin failures++; $display("FAIL b2b_accepts got=%0d exp=%0d", acc_cnt, DEPTH); end
        if (r7 !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%0b exp=0", r7); end
        if (r8 !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_pop got=%0b exp=1", r8); end
        if (r9 !== 1'b0) begin failures++; $display("FAIL b2b_ready_refill got=%0b exp=0", r9); end
        for (int f = 0; f < 4; f++) begin
            checks += 3;
            if (acc.size() <= f) begin
                failures++; $display("FAIL b2b_order f=%0d got=missing exp=present", f);
            end else begin
                if (obs_left[f] !== acc[f]) begin failures++; $display("FAIL b2b_order_left f=%0d got=%h exp=%h", f, obs_left[f], acc[f]); end
                if (obs_right[f] !== acc[f]) begin failures++; $display("FAIL b2b_order_right f=%0d got=%h exp=%h", f, obs_right[f], acc[f]); end
            end
            if (und_cnt[f] != 0) begin failures++; $display("FAIL b2b_underrun f=%0d got=%0d exp=0", f, und_cnt[f]); end
        end
    endtask

    task automatic test_coincident();
        logic und8;
        do_reset();
        wait_until(7);
        data_in = 16'h7FFF; in_valid = 1'b1;
        wait_edges(1);
        in_valid = 1'b0;
        und8 = underrun;
        wait_until(2 * FRAME + 4);
        checks += 5;
        if (und8 !== 1'b1) begin failures++; $display("FAIL coinc_underrun_pulse got=%0b exp=1", und8); end
        if (obs_left[0] !== 16'h0000) begin failures++; $display("FAIL coinc_frame0 got=%h exp=0000", obs_left[0]); end
        if (obs_left[1] !== 16'h7FFF) begin failures++; $display("FAIL coinc_frame1_left got=%h exp=7fff", obs_left[1]); end
        if (obs_right[1] !== 16'h7FFF) begin failures++; $display("FAIL coinc_frame1_right got=%h exp=7fff", obs_right[1]); end
        if (und_cnt[1] != 0) begin failures++; $display("FAIL coinc_frame1_underrun got=%0d exp=0", und_cnt[1]); end
    endtask

    task automatic test_mid_reset();
        int n;
        do_reset();
        data_in = 16'h1234; in_valid = 1'b1;
        wait_edges(1);
        in_valid = 1'b0;
        wait_until(8);
        data_in = 16'h4321; in_valid = 1'b1;
        n = 0;
        while (in_ready && n < 12) begin
            wait_edges(1);
            n++;
        end
        in_valid = 1'b0;
        wait_until(8 + 21 * PER - CLK_DIV);
        #1;
        checks += 2;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_pre_ready got=%0b exp=0", in_ready); end
        if (i2s_bclk !== 1'b1) begin failures++; $display("FAIL midrst_pre_bclk got=%0b exp=1", i2s_bclk); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({i2s_bclk, i2s_ws, i2s_sd, underrun, in_ready} !== 5'b00001) begin
            failures++; $display("FAIL midrst_outputs got=%b exp=00001", {i2s_bclk, i2s_ws, i2s_sd, underrun, in_ready});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        t_edge = 0;
        wait_until(FRAME + 4);
        checks += 2;
        if (und_cnt[0] != 1) begin failures++; $display("FAIL midrst_underrun got=%0d exp=1", und_cnt[0]); end
        if ({obs_left[0], obs_right[0]} !== 32'h0) begin failures++; $display("FAIL midrst_zero_frame got=%h exp=0", {obs_left[0], obs_right[0]}); end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_underrun();
        test_random();
        test_back_to_back();
        test_coincident();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per BCLK half-period; legal values 2..255.
REQ-002 SHALL have port clk  input  1  system clock, 25 MHz board clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_in  input  16  two's-complement audio sample.
REQ-005 SHALL have port in_valid  input  1  data_in is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port i2s_bclk  output  1  I2S bit clock.
REQ-008 SHALL have port i2s_ws  output  1  word select; 0 = left slot, 1 = right slot.
REQ-009 SHALL have port i2s_sd  output  1  serial data, MSB first.
REQ-010 SHALL have port underrun  output  1  one-clk pulse when a frame starts with no sample buffered.

Function
REQ-011 SHALL toggle i2s_bclk every CLK_DIV clk cycles, giving BCLK = clk/(2*CLK_DIV); default 3.125 MHz.
REQ-012 SHALL keep a 6-bit slot-bit counter, advanced on each BCLK falling edge and wrapping 63->0; wrap to 0 is "frame start"; 64 BCLK per frame.
REQ-013 SHALL update i2s_ws and i2s_sd only on the clk cycle that drives i2s_bclk 1->0.
REQ-014 SHALL drive i2s_ws = 0 for counts 0..31 and 1 for counts 32..63.
REQ-015 SHALL drive i2s_sd at slot position p = count mod 32: p=0 -> 0; p=1..16 -> sample bit 15..0; p=17..31 -> 0 (Philips one-BCLK delay).
REQ-016 SHALL transmit the same sample in the left and right slots of a frame (mono duplicated).
REQ-017 SHALL transfer a sample when in_valid && in_ready are both high on a rising clk edge; in_valid high with in_ready low SHALL be ignored, with no data loss required of the source.
REQ-018 SHALL, at frame start, pop the oldest buffered sample into the frame shift register.
REQ-019 SHALL, if the buffer is empty at frame start, transmit zeros for that frame and pulse underrun for exactly one clk.
REQ-020 SHALL treat a handshake and a frame start in the same cycle as follows: the pop uses buffer state before that edge; the new sample is stored afterwards.
REQ-021 SHALL, with buffer full and a frame start in the same cycle, deassert in_ready that cycle and reassert it on the next cycle.
REQ-022 SHALL drive in_ready = buffer not full, as a registered output.

Reset
REQ-023 SHALL, while rst_n = 0, force i2s_bclk = 0, i2s_ws = 0, i2s_sd = 0, underrun = 0, in_ready = 1, empty the buffer, clear the shift register, and set the divider to 0 and the bit counter to 63.
REQ-024 SHALL make the first BCLK falling edge after reset release a frame start (count 63->0).
REQ-025 SHALL, on reset asserted mid-frame, abandon the frame immediately and discard any buffered samples.

Configuration
REQ-026 SHALL honour macro I2S_TX_FIFO_EN: when defined, the buffer is a 4-entry FIFO; when undefined, it is a single holding register (depth 1).
REQ-027 SHALL keep the port list and all other behaviour identical in both configurations; only buffer depth and the in_ready full condition differ.

Verification
REQ-028 SHALL cover: reset release with CLK_DIV=4 -> i2s_bclk first rises at clk 4 and falls at clk 8; i2s_ws = 0 and count = 0 at that fall.
REQ-029 SHALL cover: sample 16'hA5C3 written before the first frame start -> bits 1010_0101_1100_0011 appear on i2s_sd at BCLK 1..16 and again at 33..48; all other BCLK positions read 0.
REQ-030 SHALL cover: no sample written -> frame of all zeros and exactly one underrun pulse per frame start.
REQ-031 SHALL cover: in_valid held high continuously with FIFO_EN -> in_ready drops after 4 accepts, rises one clk after each frame start, and transmitted samples stay in write order.
REQ-032 SHALL cover: handshake of 16'h7FFF coincident with a frame start while the buffer is empty -> underrun pulses; 16'h7FFF is transmitted in the next frame.
REQ-033 SHALL cover: rst_n pulled low at count 20 -> all outputs at reset values within the same clk; the restarted frame transmits zeros with underrun.
